// File: rtl/rr_index_arbiter_pkg.sv
// Shared types and sizes for the 16-way round-robin index arbiter.
// The request count is fixed at 16 so the index can feed a 4-to-16 decoder directly.
package apm_arb_pkg;

    localparam int N_REQ = 16;
    localparam int IDX_W = 4;

    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_index_arbiter_pick.sv
// Combinational round-robin pick: the first set request at or after PTR, wrapping mod 16.
// The request vector is rotated so PTR lands at bit 0, then scanned lowest-first.
module rr_pick
    import apm_arb_pkg::*;
(
    input  logic [N_REQ-1:0] REQ,
    input  idx_t             PTR,
    output logic             ANY,
    output idx_t             IDX
);

    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    idx_t               first;

    assign req_dbl = {REQ, REQ};
    assign req_rot = req_dbl[PTR +: N_REQ];

    // Scan from the top so the lowest set bit is the last assignment to stick.
    always_comb begin
        first = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                first = idx_t'(i);
            end
        end
    end

    assign ANY = |REQ;
    assign IDX = first + PTR;

endmodule

// File: rtl/rr_index_arbiter.sv
// 16-requester round-robin arbiter with a registered grant index, grant valid and timeout pulse.
// A grant is held until ACK or timeout, after which priority moves to the index after the winner.
module rr_index_arbiter
    import apm_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [N_REQ-1:0] REQ,
    input  logic             ACK,
    output logic             GNT_VALID,
    output idx_t             GNT_IDX,
    output logic             TIMEOUT_ERR,
    output arb_state_t       dbg_state_o,
    output idx_t             dbg_ptr_o
);

    localparam logic       TMO_EN   = (TIMEOUT != 0);
    localparam logic [7:0] TMO_LAST = 8'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    arb_state_t state_q;
    idx_t       ptr_q;
    logic [7:0] tcnt_q;
    logic       gnt_valid_q;
    idx_t       gnt_idx_q;
    logic       timeout_err_q;

    logic pick_any;
    idx_t pick_idx;
    logic tmo_hit;

    rr_pick u_pick (
        .REQ (REQ),
        .PTR (ptr_q),
        .ANY (pick_any),
        .IDX (pick_idx)
    );

    assign tmo_hit = TMO_EN && (tcnt_q == TMO_LAST);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            tcnt_q        <= '0;
            gnt_valid_q   <= 1'b0;
            gnt_idx_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            timeout_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        gnt_idx_q   <= pick_idx;
                        gnt_valid_q <= 1'b1;
                        tcnt_q      <= '0;
                        state_q     <= GRANT;
                    end
                end
                GRANT: begin
                    // ACK takes precedence; the error pulse only fires for a genuine timeout.
                    if (ACK || tmo_hit) begin
                        gnt_valid_q   <= 1'b0;
                        ptr_q         <= gnt_idx_q + idx_t'(1);
                        state_q       <= IDLE;
                        timeout_err_q <= ~ACK;
                    end else if (tcnt_q != 8'hFF) begin
                        tcnt_q <= tcnt_q + 8'd1;
                    end
                end
            endcase
        end
    end

    assign GNT_VALID   = gnt_valid_q;
    assign GNT_IDX     = gnt_idx_q;
    assign TIMEOUT_ERR = timeout_err_q;
    assign dbg_state_o = state_q;
    assign dbg_ptr_o   = ptr_q;

endmodule

// File: tb/tb_rr_index_arbiter.sv
// Directed bench for rr_index_arbiter built with a short timeout so expiry is reachable quickly.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_rr_index_arbiter;
    import apm_arb_pkg::*;

    logic             CLK = 1'b0;
    logic             RESET;
    logic [N_REQ-1:0] REQ;
    logic             ACK;
    logic             GNT_VALID;
    idx_t             GNT_IDX;
    logic             TIMEOUT_ERR;
    arb_state_t       dbg_state;
    idx_t             dbg_ptr;

    int checks = 0;
    int errors = 0;

    rr_index_arbiter #(.TIMEOUT(4)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .REQ         (REQ),
        .ACK         (ACK),
        .GNT_VALID   (GNT_VALID),
        .GNT_IDX     (GNT_IDX),
        .TIMEOUT_ERR (TIMEOUT_ERR),
        .dbg_state_o (dbg_state),
        .dbg_ptr_o   (dbg_ptr)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        REQ   = '0;
        ACK   = 1'b0;
        step();
        step();
        RESET = 1'b0;
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (GNT_VALID !== 1'b0 || GNT_IDX !== 4'd0 || TIMEOUT_ERR !== 1'b0 || dbg_ptr !== 4'd0) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got valid=%b idx=%0d err=%b ptr=%0d exp 0 0 0 0",
                         c, GNT_VALID, GNT_IDX, TIMEOUT_ERR, dbg_ptr);
            end
            step();
        end
    endtask

    task automatic test_alternate();
        idx_t exp_idx;
        REQ = 16'h8001;
        step();
        for (int g = 0; g < 4; g++) begin
            exp_idx = (g % 2 == 1) ? 4'd15 : 4'd0;
            checks++;
            if (GNT_VALID !== 1'b1 || GNT_IDX !== exp_idx || dbg_state !== GRANT) begin
                errors++;
                $display("FAIL alt_grant g=%0d got valid=%b idx=%0d exp valid=1 idx=%0d",
                         g, GNT_VALID, GNT_IDX, exp_idx);
            end
            step();
            checks++;
            if (GNT_VALID !== 1'b1 || GNT_IDX !== exp_idx) begin
                errors++;
                $display("FAIL alt_hold g=%0d got valid=%b idx=%0d exp valid=1 idx=%0d",
                         g, GNT_VALID, GNT_IDX, exp_idx);
            end
            ACK = 1'b1;
            if (g == 3) REQ = '0;
            step();
            ACK = 1'b0;
            checks++;
            if (GNT_VALID !== 1'b0 || dbg_ptr !== exp_idx + 4'd1) begin
                errors++;
                $display("FAIL alt_bubble g=%0d got valid=%b ptr=%0d exp valid=0 ptr=%0d",
                         g, GNT_VALID, dbg_ptr, exp_idx + 4'd1);
            end
            step();
        end
        checks++;
        if (GNT_VALID !== 1'b0 || dbg_ptr !== 4'd0) begin
            errors++;
            $display("FAIL alt_end got valid=%b ptr=%0d exp valid=0 ptr=0", GNT_VALID, dbg_ptr);
        end
    endtask

    task automatic test_full_rotation();
        REQ = 16'hFFFF;
        for (int g = 0; g <= 16; g++) begin
            step();
            checks++;
            if (GNT_VALID !== 1'b1 || GNT_IDX !== idx_t'(g % 16)) begin
                errors++;
                $display("FAIL rot_grant g=%0d got valid=%b idx=%0d exp valid=1 idx=%0d",
                         g, GNT_VALID, GNT_IDX, g % 16);
            end
            ACK = 1'b1;
            if (g == 16) REQ = '0;
            step();
            ACK = 1'b0;
            if (g == 15) begin
                checks++;
                if (GNT_VALID !== 1'b0 || dbg_ptr !== 4'd0) begin
                    errors++;
                    $display("FAIL rot_wrap got valid=%b ptr=%0d exp valid=0 ptr=0", GNT_VALID, dbg_ptr);
                end
            end
        end
        step();
        checks++;
        if (GNT_VALID !== 1'b0 || dbg_ptr !== 4'd1) begin
            errors++;
            $display("FAIL rot_end got valid=%b ptr=%0d exp valid=0 ptr=1", GNT_VALID, dbg_ptr);
        end
    endtask

    task automatic test_timeout();
        REQ = 16'h0020;
        step();
        REQ = '0;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (GNT_VALID !== 1'b1 || GNT_IDX !== 4'd5 || TIMEOUT_ERR !== 1'b0) begin
                errors++;
                $display("FAIL tmo_hold cyc=%0d got valid=%b idx=%0d err=%b exp 1 5 0",
                         c, GNT_VALID, GNT_IDX, TIMEOUT_ERR);
            end
            step();
        end
        checks++;
        if (GNT_VALID !== 1'b0 || TIMEOUT_ERR !== 1'b1 || dbg_ptr !== 4'd6) begin
            errors++;
            $display("FAIL tmo_expire got valid=%b err=%b ptr=%0d exp 0 1 6", GNT_VALID, TIMEOUT_ERR, dbg_ptr);
        end
        step();
        checks++;
        if (GNT_VALID !== 1'b0 || TIMEOUT_ERR !== 1'b0) begin
            errors++;
            $display("FAIL tmo_pulse_len got valid=%b err=%b exp 0 0", GNT_VALID, TIMEOUT_ERR);
        end
    endtask

    task automatic test_ack_at_timeout();
        REQ = 16'h0020;
        step();
        REQ = '0;
        for (int c = 0; c < 3; c++) step();
        checks++;
        if (GNT_VALID !== 1'b1 || GNT_IDX !== 4'd5) begin
            errors++;
            $display("FAIL race_fourth got valid=%b idx=%0d exp 1 5", GNT_VALID, GNT_IDX);
        end
        ACK = 1'b1;
        step();
        ACK = 1'b0;
        checks++;
        if (GNT_VALID !== 1'b0 || TIMEOUT_ERR !== 1'b0 || dbg_ptr !== 4'd6) begin
            errors++;
            $display("FAIL race_ack_wins got valid=%b err=%b ptr=%0d exp 0 0 6", GNT_VALID, TIMEOUT_ERR, dbg_ptr);
        end
        step();
        checks++;
        if (TIMEOUT_ERR !== 1'b0) begin
            errors++;
            $display("FAIL race_no_err got err=%b exp 0", TIMEOUT_ERR);
        end
    endtask

    task automatic test_ack_idle();
        ACK = 1'b1;
        step();
        step();
        ACK = 1'b0;
        checks++;
        if (GNT_VALID !== 1'b0 || dbg_state !== IDLE || dbg_ptr !== 4'd6 || GNT_IDX !== 4'd5) begin
            errors++;
            $display("FAIL idle_ack got valid=%b ptr=%0d idx=%0d exp valid=0 ptr=6 idx=5",
                     GNT_VALID, dbg_ptr, GNT_IDX);
        end
    endtask

    task automatic test_reset_mid_grant();
        REQ = 16'h0200;
        step();
        checks++;
        if (GNT_VALID !== 1'b1 || GNT_IDX !== 4'd9) begin
            errors++;
            $display("FAIL rst_grant got valid=%b idx=%0d exp 1 9", GNT_VALID, GNT_IDX);
        end
        step();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        checks++;
        if (GNT_VALID !== 1'b0 || GNT_IDX !== 4'd0 || dbg_ptr !== 4'd0 || TIMEOUT_ERR !== 1'b0) begin
            errors++;
            $display("FAIL rst_abort got valid=%b idx=%0d ptr=%0d err=%b exp 0 0 0 0",
                     GNT_VALID, GNT_IDX, dbg_ptr, TIMEOUT_ERR);
        end
        step();
        checks++;
        if (GNT_VALID !== 1'b1 || GNT_IDX !== 4'd9 || TIMEOUT_ERR !== 1'b0) begin
            errors++;
            $display("FAIL rst_regrant got valid=%b idx=%0d err=%b exp 1 9 0", GNT_VALID, GNT_IDX, TIMEOUT_ERR);
        end
        REQ = '0;
        ACK = 1'b1;
        step();
        ACK = 1'b0;
        checks++;
        if (GNT_VALID !== 1'b0 || dbg_ptr !== 4'd10) begin
            errors++;
            $display("FAIL rst_release got valid=%b ptr=%0d exp 0 10", GNT_VALID, dbg_ptr);
        end
    endtask

    initial begin
        RESET = 1'b1;
        REQ   = '0;
        ACK   = 1'b0;
        test_reset();
        test_alternate();
        test_full_rotation();
        test_timeout();
        test_ack_at_timeout();
        test_ack_idle();
        test_reset_mid_grant();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
